// File: rtl/ballot_session_if.sv
// Booth-side bundle between the officer/button logic and ballot_session_ctrl.
// The master drives the officer, mode and vote requests. The slave returns the grant, status and display signals.
interface ballot_session_if #(
  parameter int TOT_W = 8
);
  logic             mode;
  logic             ballot_issue;
  logic [3:0]       vote_req;
  logic [3:0]       vote_grant;
  logic             spoil;
  logic             timeout;
  logic             ballot_open;
  logic             lockout;
  logic [1:0]       disp_sel;
  logic [TOT_W-1:0] vote_total;

  modport master (
    output mode, ballot_issue, vote_req,
    input  vote_grant, spoil, timeout, ballot_open, lockout, disp_sel, vote_total
  );

  modport slave (
    input  mode, ballot_issue, vote_req,
    output vote_grant, spoil, timeout, ballot_open, lockout, disp_sel, vote_total
  );
endinterface

// File: rtl/ballot_session_ctrl.sv
// Polling-booth ballot sequencer: IDLE -> OPEN -> LOCK -> IDLE, with mode=1 forcing RESULT display rotation.
// Optional OPEN expiry is enabled by defining BALLOT_TIMEOUT_EN.
//   state    | meaning
//   S_IDLE   | waiting for ballot_issue
//   S_OPEN   | one ballot open, arbitrating vote_req
//   S_LOCK   | post-vote/spoil lockout countdown
//   S_RESULT | rotating disp_sel across candidates
module ballot_session_ctrl #(
  parameter int LOCK_CYCLES    = 16,
  parameter int DISP_CYCLES    = 50,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TOT_W          = 8
) (
  input logic              clk,
  input logic              reset,
  ballot_session_if.slave  bus
);

  // One down-counter serves LOCK, RESULT dwell and OPEN expiry; they never overlap.
  localparam int MAX_A = (LOCK_CYCLES > DISP_CYCLES) ? LOCK_CYCLES : DISP_CYCLES;
  localparam int MAX_C = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int CNT_W = (MAX_C > 1) ? $clog2(MAX_C) : 1;
  localparam logic [CNT_W-1:0] LOCK_LD = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DISP_LD = CNT_W'(DISP_CYCLES - 1);
`ifdef BALLOT_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_LD  = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [1:0] {S_IDLE, S_OPEN, S_LOCK, S_RESULT} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_grant;
  logic             r_spoil;
  logic [1:0]       r_disp;
  logic [TOT_W-1:0] r_total;
  logic [3:0]       w_req_lo;
  logic             w_multi;
  logic             w_single;
`ifdef BALLOT_TIMEOUT_EN
  logic             r_timeout;
`endif

  // Clearing the lowest set bit leaves something only when two or more bits are set.
  assign w_req_lo = bus.vote_req & (bus.vote_req - 4'd1);
  assign w_multi  = |w_req_lo;
  assign w_single = (|bus.vote_req) & ~w_multi;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_grant <= '0;
      r_spoil <= 1'b0;
      r_disp  <= '0;
      r_total <= '0;
`ifdef BALLOT_TIMEOUT_EN
      r_timeout <= 1'b0;
`endif
    end else begin
      r_grant <= '0;
      r_spoil <= 1'b0;
`ifdef BALLOT_TIMEOUT_EN
      r_timeout <= 1'b0;
`endif
      if (bus.mode) begin
        r_state <= S_RESULT;
        if (r_state != S_RESULT) begin
          r_cnt  <= DISP_LD;
          r_disp <= '0;
        end else if (r_cnt == '0) begin
          r_cnt  <= DISP_LD;
          r_disp <= r_disp + 2'd1;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.ballot_issue) begin
              r_state <= S_OPEN;
`ifdef BALLOT_TIMEOUT_EN
              r_cnt   <= TMO_LD;
`endif
            end
          end
          S_OPEN: begin
            if (w_single) begin
              r_grant <= bus.vote_req;
              r_state <= S_LOCK;
              r_cnt   <= LOCK_LD;
              if (r_total != {TOT_W{1'b1}}) r_total <= r_total + TOT_W'(1);
            end else if (w_multi) begin
              r_spoil <= 1'b1;
              r_state <= S_LOCK;
              r_cnt   <= LOCK_LD;
`ifdef BALLOT_TIMEOUT_EN
            end else if (r_cnt == '0) begin
              r_timeout <= 1'b1;
              r_state   <= S_IDLE;
            end else begin
              r_cnt <= r_cnt - 1'b1;
`endif
            end
          end
          S_LOCK: begin
            if (r_cnt == '0) r_state <= S_IDLE;
            else             r_cnt   <= r_cnt - 1'b1;
          end
          S_RESULT: begin
            r_state <= S_IDLE;
            r_disp  <= '0;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.vote_grant  = r_grant;
  assign bus.spoil       = r_spoil;
  assign bus.ballot_open = (r_state == S_OPEN);
  assign bus.lockout     = (r_state == S_LOCK);
  assign bus.disp_sel    = r_disp;
  assign bus.vote_total  = r_total;
`ifdef BALLOT_TIMEOUT_EN
  assign bus.timeout     = r_timeout;
`else
  assign bus.timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_ballot_session_ctrl.sv
// Self-checking bench for ballot_session_ctrl: directed booth scenarios, then random traffic.
// A cycle-level behavioural model of the booth supplies the expected outputs.
module tb_ballot_session_ctrl;
  localparam int LOCK = 16;
  localparam int DISP = 50;
  localparam int TMO  = 8;
  localparam int TW   = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ballot_session_if #(.TOT_W(TW)) bus ();

  ballot_session_ctrl #(
    .LOCK_CYCLES(LOCK), .DISP_CYCLES(DISP), .TIMEOUT_CYCLES(TMO), .TOT_W(TW)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Booth model: flags and elapsed-cycle counts rather than an encoded state.
  bit         m_open, m_result;
  int         m_lock_left, m_result_age, m_open_age, m_votes;
  logic [3:0] e_grant;
  bit         e_spoil, e_tmo;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_total();
    int cap = (1 << TW) - 1;
    return (m_votes > cap) ? cap : m_votes;
  endfunction

  function automatic int exp_disp();
    return m_result ? (m_result_age / DISP) % 4 : 0;
  endfunction

  task automatic model_step(input bit m, input bit iss, input logic [3:0] req, input bit rst);
    int n;
    e_grant = '0; e_spoil = 0; e_tmo = 0;
    n = $countones(req);
    if (rst) begin
      m_open = 0; m_result = 0; m_lock_left = 0; m_result_age = 0; m_open_age = 0; m_votes = 0;
    end else if (m) begin
      if (m_result) m_result_age++;
      else begin m_result = 1; m_result_age = 0; end
      m_open = 0; m_lock_left = 0;
    end else if (m_result) begin
      m_result = 0; m_result_age = 0;
    end else if (m_open) begin
      if (n == 1) begin
        e_grant = req; m_votes++; m_open = 0; m_lock_left = LOCK;
      end else if (n >= 2) begin
        e_spoil = 1; m_open = 0; m_lock_left = LOCK;
      end else begin
        m_open_age++;
`ifdef BALLOT_TIMEOUT_EN
        if (m_open_age == TMO) begin e_tmo = 1; m_open = 0; end
`endif
      end
    end else if (m_lock_left > 0) begin
      m_lock_left--;
    end else if (iss) begin
      m_open = 1; m_open_age = 0;
    end
  endtask

  task automatic check_all();
    chk("grant",   bus.vote_grant,  e_grant);
    chk("spoil",   bus.spoil,       e_spoil);
    chk("timeout", bus.timeout,     e_tmo);
    chk("open",    bus.ballot_open, m_open);
    chk("lockout", bus.lockout,     m_lock_left > 0);
    chk("disp",    bus.disp_sel,    exp_disp());
    chk("total",   bus.vote_total,  exp_total());
  endtask

  task automatic cyc(input bit m, input bit iss, input logic [3:0] req);
    bus.mode = m; bus.ballot_issue = iss; bus.vote_req = req;
    @(posedge clk);
    model_step(m, iss, req, reset);
    #1;
    check_all();
  endtask

  task automatic do_vote(input logic [3:0] req);
    cyc(0, 1, 4'b0000);
    cyc(0, 0, req);
    repeat (LOCK) cyc(0, 0, 4'b0000);
  endtask

  initial begin
    bit         r_mode;
    logic [3:0] r_req;
    int         sel;

    bus.mode = 0; bus.ballot_issue = 0; bus.vote_req = '0;
    reset = 1;
    cyc(0, 0, 4'b0000);
    cyc(0, 1, 4'b1111);
    chk("reset_total", bus.vote_total, 0);
    chk("reset_open", bus.ballot_open, 0);
    reset = 0;

    // Single valid vote, then a full lockout.
    cyc(0, 1, 4'b0000);
    chk("t1_open", bus.ballot_open, 1);
    cyc(0, 0, 4'b0100);
    chk("t1_grant", bus.vote_grant, 4'b0100);
    chk("t1_total", bus.vote_total, 1);
    repeat (LOCK - 1) cyc(0, 0, 4'b0000);
    chk("t1_lock_last", bus.lockout, 1);
    cyc(0, 0, 4'b0000);
    chk("t1_lock_done", bus.lockout, 0);

    // Simultaneous requests spoil the ballot.
    cyc(0, 1, 4'b0000);
    cyc(0, 0, 4'b0011);
    chk("t2_spoil", bus.spoil, 1);
    chk("t2_grant", bus.vote_grant, 0);
    chk("t2_total", bus.vote_total, 1);
    chk("t2_lock", bus.lockout, 1);
    repeat (LOCK) cyc(0, 0, 4'b0000);

    // No ballot: request ignored; issue during LOCK ignored.
    cyc(0, 0, 4'b0001);
    chk("t3_nogrant", bus.vote_grant, 0);
    cyc(0, 1, 4'b0000);
    cyc(0, 0, 4'b1000);
    chk("t3_total", bus.vote_total, 2);
    cyc(0, 1, 4'b0000);
    repeat (LOCK - 1) cyc(0, 0, 4'b0000);
    chk("t3_idle_lock", bus.lockout, 0);
    chk("t3_idle_open", bus.ballot_open, 0);

    // Issue and request together: ballot opens, request dropped.
    cyc(0, 1, 4'b0010);
    chk("t3_drop_grant", bus.vote_grant, 0);
    chk("t3_drop_open", bus.ballot_open, 1);
    cyc(0, 0, 4'b0000);
    chk("t3_still_open", bus.ballot_open, 1);

    // Result mode aborts the open ballot and rotates the display.
    cyc(1, 0, 4'b0001);
    chk("t4_abort_grant", bus.vote_grant, 0);
    chk("t4_abort_open", bus.ballot_open, 0);
    repeat (DISP - 1) cyc(1, 0, 4'b0000);
    chk("t4_disp0_end", bus.disp_sel, 0);
    cyc(1, 0, 4'b0000);
    chk("t4_disp1", bus.disp_sel, 1);
    for (int k = 2; k <= 4; k++) begin
      repeat (DISP) cyc(1, 0, 4'b0000);
      chk("t4_disp_step", bus.disp_sel, k % 4);
    end
    cyc(0, 0, 4'b0000);
    chk("t4_exit_disp", bus.disp_sel, 0);
    chk("t4_exit_open", bus.ballot_open, 0);

    // Saturation at 2^TW-1 after five valid ballots.
    do_vote(4'b0001);
    do_vote(4'b0010);
    do_vote(4'b1000);
    chk("t5_saturate", bus.vote_total, 3);

    // Reset while a ballot is open.
    cyc(0, 1, 4'b0000);
    reset = 1;
    cyc(0, 0, 4'b0001);
    reset = 0;
    chk("rst_mid_grant", bus.vote_grant, 0);
    chk("rst_mid_total", bus.vote_total, 0);

`ifdef BALLOT_TIMEOUT_EN
    cyc(0, 1, 4'b0000);
    repeat (TMO - 1) cyc(0, 0, 4'b0000);
    chk("t6_pre_tmo", bus.timeout, 0);
    cyc(0, 0, 4'b0000);
    chk("t6_tmo", bus.timeout, 1);
    chk("t6_tmo_nolock", bus.lockout, 0);
    cyc(0, 0, 4'b0000);
    cyc(0, 1, 4'b0000);
    repeat (TMO - 1) cyc(0, 0, 4'b0000);
    cyc(0, 0, 4'b0010);
    chk("t6_last_grant", bus.vote_grant, 4'b0010);
    chk("t6_last_notmo", bus.timeout, 0);
    repeat (LOCK) cyc(0, 0, 4'b0000);
`endif

    // Random traffic against the model.
    r_mode = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 2) r_mode = ~r_mode;
      sel = $urandom_range(0, 9);
      if (sel < 5)      r_req = 4'b0000;
      else if (sel < 8) r_req = 4'(1 << $urandom_range(0, 3));
      else              r_req = 4'($urandom_range(0, 15));
      reset = ($urandom_range(0, 499) == 0);
      cyc(r_mode, $urandom_range(0, 9) < 3, r_req);
    end
    reset = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
